// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared FSM encoding and constants for the instruction memory responder
package risc_v_pkg;
  localparam int DEF_WORD_LENGTH = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x WORD_LENGTH storage, one synchronous write port, combinational read port
module imem_array
  import risc_v_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WORD_LENGTH-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WORD_LENGTH-1:0]   rd_data
);
  logic [WORD_LENGTH-1:0] mem [DEPTH];
  // contents are never reset; the load port is the only writer
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency fetch responder; IMEM_ACCESS_CHECK_EN enables misaligned/out-of-range faults
module instr_mem_responder
  import risc_v_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WORD_LENGTH-1:0]   req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_LENGTH-1:0]   rsp_data,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WORD_LENGTH-1:0]   ld_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  imem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q, req_idx, rd_idx;
  logic err_q, req_err, rd_err, enter_resp;
  logic [WORD_LENGTH-1:0] rd_data;
  assign req_idx = req_addr[AW+1:2];
`ifdef IMEM_ACCESS_CHECK_EN
  assign req_err = |req_addr[1:0] || |req_addr[WORD_LENGTH-1:AW+2];
`else
  logic addr_unused;
  assign req_err = 1'b0;
  assign addr_unused = ^{req_addr[WORD_LENGTH-1:AW+2], req_addr[1:0]};
`endif
  // with LATENCY==1 the read happens on the accept edge itself, so bypass the latches
  assign rd_idx = state_q == IDLE ? req_idx : idx_q;
  assign rd_err = state_q == IDLE ? req_err : err_q;
  assign enter_resp = state_d == RESP && state_q != RESP;
  imem_array #(.WORD_LENGTH(WORD_LENGTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .wr_en(ld_en),
    .wr_addr(ld_addr),
    .wr_data(ld_data),
    .rd_addr(rd_idx),
    .rd_data(rd_data)
  );
  // state register plus request latch and wait-state counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        idx_q <= req_idx;
        err_q <= req_err;
        cnt_q <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  // next state: one transaction outstanding, WAIT counts down to RESP
  always_comb
    state_d = state_q == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
              state_q == WAIT ? (cnt_q == '0 ? RESP : WAIT) :
              state_q == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
  end
  // capture the word on RESP entry; held until the next transaction reaches RESP
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (enter_resp) begin
      rsp_data <= rd_err ? WORD_LENGTH'(RV_NOP) : rd_data;
      rsp_err <= rd_err;
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for LATENCY=2 and LATENCY=1 responders
module tb_instr_mem_responder;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, rsp_data;
  logic req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, rsp_data1;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_model [DEPTH];
  logic [32:0] exp_q[$];
  logic [32:0] exp1_q[$];
  logic [32:0] e0, e1;
  int hs1_t[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  instr_mem_responder #(.WORD_LENGTH(32), .DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  instr_mem_responder #(.WORD_LENGTH(32), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] expect_of(input logic [31:0] a);
`ifdef IMEM_ACCESS_CHECK_EN
    if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4)) return {1'b1, 32'h0000_0013};
`endif
    return {1'b0, mem_model[a[AW+1:2]]};
  endfunction

  always @(negedge clk) begin
    if (reset && req_valid && req_ready) exp_q.push_back(expect_of(req_addr));
    if (reset && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb0 unexpected response got %h", {rsp_err, rsp_data});
      end else begin
        e0 = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== e0) begin
          miscompares++;
          $display("FAIL sb0 got %h expected %h", {rsp_err, rsp_data}, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && req_valid1 && req_ready1) exp1_q.push_back(expect_of(req_addr1));
    if (reset && rsp_valid1 && rsp_ready1) begin
      vectors++;
      hs1_t.push_back(cyc);
      if (exp1_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb1 unexpected response got %h", {rsp_err1, rsp_data1});
      end else begin
        e1 = exp1_q.pop_front();
        if ({rsp_err1, rsp_data1} !== e1) begin
          miscompares++;
          $display("FAIL sb1 got %h expected %h", {rsp_err1, rsp_data1}, e1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = AW'(idx);
    ld_data = d;
    tick();
    ld_en = 1'b0;
    mem_model[idx] = d;
  endtask

  task automatic issue(input logic [31:0] a, output int lat);
    int n;
    req_valid = 1'b1;
    req_addr = a;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 0; req_addr = 0; rsp_ready = 1;
    req_valid1 = 0; req_addr1 = 0; rsp_ready1 = 1;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    #2 reset = 1'b0;
    tick();
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    vectors++; if (rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h expected 0", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b expected 0", rsp_err); end
    vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid1 got %b expected 0", rsp_valid1); end
    reset = 1'b1;
    tick();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
  endtask

  task automatic test_basic();
    load(5, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h14;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_idle got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_t1 got %b expected 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_t1 got %b expected 0", req_ready); end
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_t2 got %b expected 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL basic_data got %h expected deadbeef", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b expected 0", rsp_err); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_t2 got %b expected 0", req_ready); end
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop got %b expected 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_back got %b expected 1", req_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    issue(32'h14, lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL bp_latency got %0d expected 2", lat); end
    req_valid = 1'b1;
    req_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || req_ready !== 1'b0)
        begin miscompares++; $display("FAIL bp_hold[%0d] got v=%b d=%h r=%b expected v=1 d=deadbeef r=0", i, rsp_valid, rsp_data, req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_consume got %b expected 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready got %b expected 1", req_ready); end
  endtask

  task automatic test_load_collision();
    int lat;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    load(5, 32'h1234_5678);
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL coll_valid got %b expected 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL coll_old_data got %h expected deadbeef", rsp_data); end
    tick();
    issue(32'h14, lat);
    vectors++; if (rsp_data !== 32'h1234_5678) begin miscompares++; $display("FAIL coll_new_data got %h expected 12345678", rsp_data); end
    tick();
  endtask

  task automatic test_access_check();
    int lat;
    rsp_ready = 1'b1;
`ifdef IMEM_ACCESS_CHECK_EN
    issue(32'h16, lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL chk_mis_latency got %0d expected 2", lat); end
    vectors++; if (rsp_err !== 1'b1 || rsp_data !== 32'h13) begin miscompares++; $display("FAIL chk_misaligned got e=%b d=%h expected e=1 d=00000013", rsp_err, rsp_data); end
    tick();
    issue(32'(DEPTH * 4), lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL chk_oor_latency got %0d expected 2", lat); end
    vectors++; if (rsp_err !== 1'b1 || rsp_data !== 32'h13) begin miscompares++; $display("FAIL chk_out_of_range got e=%b d=%h expected e=1 d=00000013", rsp_err, rsp_data); end
    tick();
`else
    issue(32'(DEPTH * 4 + 32'h14), lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL wrap_latency got %0d expected 2", lat); end
    vectors++; if (rsp_err !== 1'b0 || rsp_data !== 32'h1234_5678) begin miscompares++; $display("FAIL wrap got e=%b d=%h expected e=0 d=12345678", rsp_err, rsp_data); end
    tick();
`endif
  endtask

  task automatic test_reset_in_wait();
    int lat;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rw_in_wait got %b expected 0", req_ready); end
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rw_valid_now got %b expected 0", rsp_valid); end
    tick();
    tick();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rw_valid_held got %b expected 0", rsp_valid); end
    reset = 1'b1;
    tick();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rw_ready_after got %b expected 1", req_ready); end
    issue(32'h14, lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL rw_latency got %0d expected 2", lat); end
    vectors++; if (rsp_data !== 32'h1234_5678) begin miscompares++; $display("FAIL rw_retained got %h expected 12345678", rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc, n;
    for (int i = 0; i < 8; i++) load(16 + i, 32'hA000_0000 + 32'(i * 32'h111));
    hs1_t.delete();
    rsp_ready1 = 1'b1;
    acc = 0;
    n = 0;
    req_valid1 = 1'b1;
    req_addr1 = 32'(16 * 4);
    while (acc < 8 && n < 100) begin
      if (req_ready1) begin
        tick();
        acc++;
        req_addr1 = 32'((16 + acc) * 4);
      end else tick();
      n++;
    end
    req_valid1 = 1'b0;
    repeat (3) tick();
    vectors++; if (hs1_t.size() != 8) begin miscompares++; $display("FAIL b2b_count got %0d expected 8", hs1_t.size()); end
    for (int i = 1; i < hs1_t.size(); i++) begin
      vectors++; if (hs1_t[i] - hs1_t[i-1] != 2) begin miscompares++; $display("FAIL b2b_gap[%0d] got %0d expected 2", i, hs1_t[i] - hs1_t[i-1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_collision();
    test_access_check();
    test_reset_in_wait();
    test_back_to_back();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb0_leftover got %0d expected 0", exp_q.size()); end
    vectors++; if (exp1_q.size() != 0) begin miscompares++; $display("FAIL sb1_leftover got %0d expected 0", exp1_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end
endmodule
